// File: rtl/rom_sweep_reader_if.sv
// ROM read bus plus the address-tagged output stream of rom_sweep_reader.
// The master side is the sweep engine; the slave side is the ROM together with the consumer.
interface rom_sweep_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/rom_sweep_reader.sv
// Sweep engine for the synchronous rom: walks a modular address range, absorbs the read
// latency in a small return FIFO and streams address-tagged bytes with a running checksum.
module rom_sweep_reader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  end_addr,
  rom_sweep_reader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        checksum
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("rom_sweep_reader: READ_LATENCY must be in 1..3");
  end
  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("rom_sweep_reader: FIFO_DEPTH must be >= READ_LATENCY+1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]     span_m1;
  logic [ADDR_W:0]       span;
  logic [ADDR_W:0]       remain;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic                  room;
  logic                  fire;
  logic                  push;
  logic [ADDR_W-1:0]     issue_addr;

  logic [READ_LATENCY:0] pipe_vld;
  logic [READ_LATENCY:0] pipe_last;
  logic [ADDR_W-1:0]     pipe_addr [READ_LATENCY+1];

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The span is one wider than the address so a full wrap (end == start-1) counts 2^ADDR_W words.
  assign span_m1 = end_addr - start_addr;
  assign span    = {1'b0, span_m1} + (ADDR_W+1)'(1);
  assign room    = (int'($countones(pipe_vld)) + int'(fifo_cnt)) < FIFO_DEPTH;
  assign fire    = bus.out_valid && bus.out_ready;
  assign push    = pipe_vld[READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          issue      = 1'b1;
          issue_last = (span == (ADDR_W+1)'(1));
          state_nxt  = issue_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (room) begin
          issue      = 1'b1;
          issue_last = (remain == (ADDR_W+1)'(1));
          if (issue_last) state_nxt = DRAIN;
        end
      end
      // The last-tagged word leaves only after every earlier read has been returned and popped.
      DRAIN:   if (fire && bus.out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_addr = accept ? start_addr : bus.rom_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_addr <= '0;
      remain       <= '0;
      pipe_vld     <= '0;
      pipe_last    <= '0;
      checksum     <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld     <= {pipe_vld[READ_LATENCY-1:0], issue};
      pipe_last    <= {pipe_last[READ_LATENCY-1:0], issue_last};
      pipe_addr[0] <= issue_addr;
      for (int i = 1; i <= READ_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
      if (issue) bus.rom_addr <= issue_addr;
      if (accept)     remain <= span - (ADDR_W+1)'(1);
      else if (issue) remain <= remain - (ADDR_W+1)'(1);
      if (accept)    checksum <= '0;
      else if (fire) checksum <= checksum + 16'(bus.out_data);
    end
  end

  // Return FIFO: the issue rule reserves a slot per outstanding read, so push never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.rom_data;
        fifo_addr[wr_ptr] <= pipe_addr[READ_LATENCY];
        fifo_last[wr_ptr] <= pipe_last[READ_LATENCY];
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (fire) rd_ptr <= next_ptr(rd_ptr);
      case ({push, fire})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_addr  = bus.out_valid ? fifo_addr[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid && fifo_last[rd_ptr];
  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);
endmodule

// File: tb/tb_rom_sweep_reader.sv
// Directed bench for rom_sweep_reader: two instances (READ_LATENCY 1 and 3) see identical
// stimulus, each against its own ROM model with data = (addr*3) mod 256.
module tb_rom_sweep_reader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  end_addr;
  logic        out_ready;
  logic        busy1, done1, busy3, done3;
  logic [15:0] cs1, cs3;

  rom_sweep_reader_if #(.ADDR_W(10), .DATA_W(8)) bus1 ();
  rom_sweep_reader_if #(.ADDR_W(10), .DATA_W(8)) bus3 ();

  rom_sweep_reader #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .bus(bus1.master), .busy(busy1), .done(done1), .checksum(cs1));

  rom_sweep_reader #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .bus(bus3.master), .busy(busy3), .done(done3), .checksum(cs3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [9:0] a);
    logic [11:0] p;
    p = {2'b00, a} * 12'd3;
    return p[7:0];
  endfunction

  logic [7:0] rom1_q;
  logic [7:0] rom3_q [3];
  always @(posedge clk) begin
    rom1_q    <= rom_model(bus1.rom_addr);
    rom3_q[0] <= rom_model(bus3.rom_addr);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign bus1.rom_data  = rom1_q;
  assign bus3.rom_data  = rom3_q[2];
  assign bus1.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks, errors;
  int          cap_addr [2][2048];
  int          cap_data [2][2048];
  int          cap_last [2][2048];
  int          cap_n [2], done_cnt [2], busy_err [2], stall_err [2];
  int          valid_seen [2], first_v [2], fmax [2];
  int          start_cyc;
  logic        prev_stall [2];
  logic [18:0] prev_pay [2];
  bit          pat_mode;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic monitor_step(input int k, input logic v, input logic r, input logic [9:0] a,
                              input logic [7:0] d, input logic l, input logic dn, input logic bz);
    logic [18:0] pay;
    pay = {a, d, l};
    if (prev_stall[k] && (!v || pay != prev_pay[k])) stall_err[k]++;
    prev_stall[k] = v && !r;
    prev_pay[k]   = pay;
    if (v) begin
      valid_seen[k]++;
      if (first_v[k] < 0) first_v[k] = cyc;
    end
    if (v && r) begin
      if (cap_n[k] < 2048) begin
        cap_addr[k][cap_n[k]] = int'(a);
        cap_data[k][cap_n[k]] = int'(d);
        cap_last[k][cap_n[k]] = int'(l);
      end
      cap_n[k]++;
    end
    if (dn) begin
      done_cnt[k]++;
      if (bz) busy_err[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitor_step(0, bus1.out_valid, bus1.out_ready, bus1.out_addr, bus1.out_data, bus1.out_last, done1, busy1);
      monitor_step(1, bus3.out_valid, bus3.out_ready, bus3.out_addr, bus3.out_data, bus3.out_last, done3, busy3);
      if (int'(dut1.fifo_cnt) > fmax[0]) fmax[0] = int'(dut1.fifo_cnt);
      if (int'(dut3.fifo_cnt) > fmax[1]) fmax[1] = int'(dut3.fifo_cnt);
    end else begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end
  end

  // 3-low/1-high backpressure when pat_mode is set, otherwise always ready.
  initial begin
    int phase;
    phase     = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pat_mode) begin
        out_ready = (phase == 3);
        phase     = (phase + 1) % 4;
      end else begin
        out_ready = 1'b1;
        phase     = 0;
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      cap_n[k] = 0; done_cnt[k] = 0; busy_err[k] = 0; stall_err[k] = 0;
      valid_seen[k] = 0; first_v[k] = -1; fmax[k] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [9:0] sa, input logic [9:0] ea, input int n,
                               input int second_at, output bit timed_out);
    int budget;
    clear_stats();
    budget = 6 * n + 100;
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = sa; end_addr = ea; start_cyc = cyc;
    timed_out = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      start      = (second_at > 0 && i == second_at);
      start_addr = sa + 10'd37;
      end_addr   = ea ^ 10'h155;
      if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verify_stream(input string tag, input logic [9:0] sa, input int n,
                               input int exp_sum, input bit timed_out);
    string nm;
    int    bad, ea;
    checkOutput({tag, " timeout"}, 64'(timed_out), 64'd0);
    for (int k = 0; k < 2; k++) begin
      nm = $sformatf("%s L%0d", tag, (k == 0) ? 1 : 3);
      checkOutput({nm, " count"}, 64'(cap_n[k]), 64'(n));
      bad = 0;
      for (int i = 0; i < cap_n[k] && i < 2048; i++) begin
        ea = (int'(sa) + i) % 1024;
        if (cap_addr[k][i] != ea || cap_data[k][i] != (ea * 3) % 256 ||
            cap_last[k][i] != int'(i == n - 1)) bad++;
      end
      checkOutput({nm, " bad words"}, 64'(bad), 64'd0);
      checkOutput({nm, " checksum"}, 64'((k == 0) ? cs1 : cs3), 64'(exp_sum));
      checkOutput({nm, " done pulses"}, 64'(done_cnt[k]), 64'd1);
      checkOutput({nm, " busy during done"}, 64'(busy_err[k]), 64'd0);
      checkOutput({nm, " stall stability"}, 64'(stall_err[k]), 64'd0);
    end
  endtask

  function automatic logic [63:0] outs1();
    return 64'({bus1.rom_addr, bus1.out_valid, bus1.out_data, bus1.out_addr, bus1.out_last, busy1, done1, cs1});
  endfunction
  function automatic logic [63:0] outs3();
    return 64'({bus3.rom_addr, bus3.out_valid, bus3.out_data, bus3.out_addr, bus3.out_last, busy3, done3, cs3});
  endfunction

  initial begin
    bit to;
    bit found;
    int full_sum;
    int e_addr [4];
    int e_data [4];
    checks = 0; errors = 0; pat_mode = 1'b0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs L1", outs1(), 64'd0);
    checkOutput("reset outputs L3", outs3(), 64'd0);
    rst_n = 1'b1;

    // Basic sweep 0..3 with hand-computed data and latency.
    applyStimulus(10'd0, 10'd3, 4, 0, to);
    verify_stream("t1", 10'd0, 4, 18, to);
    e_addr = '{0, 1, 2, 3};
    e_data = '{0, 3, 6, 9};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i < cap_n[k]) begin
          checkOutput($sformatf("t1 L%0d word%0d addr", k*2+1, i), 64'(cap_addr[k][i]), 64'(e_addr[i]));
          checkOutput($sformatf("t1 L%0d word%0d data", k*2+1, i), 64'(cap_data[k][i]), 64'(e_data[i]));
          checkOutput($sformatf("t1 L%0d word%0d last", k*2+1, i), 64'(cap_last[k][i]), 64'(i == 3));
        end
      end
    end
    checkOutput("t1 first valid latency L1", 64'(first_v[0] - start_cyc), 64'd3);
    checkOutput("t1 first valid latency L3", 64'(first_v[1] - start_cyc), 64'd5);

    // Wrap through the top of the address space.
    applyStimulus(10'd1022, 10'd1, 4, 0, to);
    verify_stream("t2", 10'd1022, 4, 506, to);
    e_addr = '{1022, 1023, 0, 1};
    e_data = '{250, 253, 0, 3};
    for (int i = 0; i < 4; i++) begin
      if (i < cap_n[0]) begin
        checkOutput($sformatf("t2 L1 word%0d addr", i), 64'(cap_addr[0][i]), 64'(e_addr[i]));
        checkOutput($sformatf("t2 L1 word%0d data", i), 64'(cap_data[0][i]), 64'(e_data[i]));
      end
    end

    // end == start-1 covers the whole ROM.
    full_sum = 0;
    for (int a = 0; a < 1024; a++) full_sum = (full_sum + (a * 3) % 256) % 65536;
    applyStimulus(10'd5, 10'd4, 1024, 0, to);
    verify_stream("t3", 10'd5, 1024, full_sum, to);

    // Backpressure: 3 cycles low, 1 high.
    pat_mode = 1'b1;
    applyStimulus(10'd0, 10'd15, 16, 0, to);
    pat_mode = 1'b0;
    verify_stream("t4", 10'd0, 16, 360, to);
    checkOutput("t4 fifo bound L1", 64'(fmax[0] <= 4), 64'd1);
    checkOutput("t4 fifo bound L3", 64'(fmax[1] <= 4), 64'd1);

    // Second start during the sweep is ignored.
    applyStimulus(10'd0, 10'd7, 8, 2, to);
    verify_stream("t5", 10'd0, 8, 84, to);

    // Asynchronous reset in the middle of the third transfer.
    clear_stats();
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 10'd0; end_addr = 10'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (cap_n[0] == 2 && bus1.out_valid && bus1.out_ready) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t6 third transfer reached", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async reset L1", outs1(), 64'd0);
    checkOutput("t6 async reset L3", outs3(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6 idle after reset L1", 64'(valid_seen[0]), 64'd0);
    checkOutput("t6 idle after reset L3", 64'(valid_seen[1]), 64'd0);
    applyStimulus(10'd0, 10'd1, 2, 0, to);
    verify_stream("t6", 10'd0, 2, 3, to);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_sweep_reader.md
Name: rom_sweep_reader

Overview:
- Synthesizable read-side master for the synchronous `rom` block.
- On a start pulse it walks an address range and drives the ROM address bus. It accounts for the ROM read latency and streams each returned byte, tagged with its address, over a valid/ready interface with backpressure.
- Keeps a running 16-bit checksum of the bytes.
- Used as an on-chip sweep engine wherever `rom` is instantiated, and as a pre/post-route comparison source.

Parameters:
- ADDR_W, 10, ROM address width.
- DATA_W, 8, ROM data width.
- READ_LATENCY, 1, cycles from `rom_addr` change (sampled at posedge) to valid `rom_data`; legal range 1..3.
- FIFO_DEPTH, 4, internal return buffer entries; must be >= READ_LATENCY+1 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy=1.
- start_addr  input  ADDR_W  first address, sampled when start is accepted.
- end_addr  input  ADDR_W  last address inclusive, sampled when start is accepted.
- rom_addr  output  ADDR_W  address to the ROM.
- rom_data  input  DATA_W  data returned by the ROM.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer ready.
- out_data  output  DATA_W  returned byte.
- out_addr  output  ADDR_W  address the byte was read from.
- out_last  output  1  marks the final word of the sweep.
- busy  output  1  high from start acceptance until the last word is transferred.
- done  output  1  one-cycle pulse the cycle after the last transfer.
- checksum  output  16  sum of all transferred bytes, mod 2^16.

Behaviour:
- Reset values (async, all outputs): rom_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, checksum=0. Internal FIFO and counters are cleared and the state is IDLE.
- Reset mid-sweep aborts immediately. In-flight reads are discarded. There is no output activity until the next start.
- FSM states:
  - IDLE: start → RUN, busy=1, checksum cleared to 0 in the same cycle. The remaining count is latched as ((end_addr - start_addr) mod 2^ADDR_W) + 1.
  - RUN: issue addresses. After the last address is issued → DRAIN.
  - DRAIN: wait until all outstanding reads have returned and the FIFO is empty → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Range arithmetic:
  - Address increments modulo 2^ADDR_W.
  - end_addr < start_addr wraps through the maximum address.
  - start_addr == end_addr reads exactly 1 word.
  - end_addr == start_addr-1 (mod) reads the full 2^ADDR_W words.
- Issue rule: a new rom_addr is presented in a cycle only if (outstanding reads + FIFO occupancy) < FIFO_DEPTH. Otherwise rom_addr holds its value and no read is counted. This guarantees the FIFO never overflows under any out_ready pattern.
- Return path:
  - A read issued at cycle t captures rom_data at cycle t+READ_LATENCY into the FIFO, together with its address and a last flag.
  - A delay-line shift register of valid bits tracks outstanding reads.
- Stream rules:
  - out_valid, out_data, out_addr and out_last come from the FIFO head.
  - Once out_valid=1, the payload is held stable until out_valid && out_ready.
  - A simultaneous FIFO push and pop is allowed when the FIFO is full.
  - Words leave in strictly increasing (modular) address order.
- Latency: with out_ready held at 1 and READ_LATENCY=1, the first out_valid occurs 3 cycles after the start cycle. Throughput is then 1 word per cycle.
- checksum updates on each transfer. Its value is final when done pulses and holds until the next accepted start.
- A start asserted while busy=1, or in the DONE cycle, is ignored (no queuing).

Test Plan:
- ROM model data=(addr*3)[7:0], start_addr=0, end_addr=3, out_ready=1 → 4 words with addr 0..3 and data 0,3,6,9. out_last on addr 3. checksum=18. done pulses once and busy drops in the same cycle.
- start_addr=1022, end_addr=1 → addresses 1022,1023,0,1 in order, data 250,253,0,3, checksum=506.
- start_addr=5, end_addr=4 → exactly 1024 words. checksum equals the sum of the model over all addresses mod 65536. No repeated or missing address.
- out_ready toggles as a 3-low/1-high pattern, range 0..15, READ_LATENCY=3 → no lost or duplicated words. Payload is stable while stalled. FIFO occupancy never exceeds 4.
- Second start pulse during a sweep of 0..7 → ignored. Exactly 8 words are produced and start_addr/end_addr changes have no effect.
- rst_n asserted low during the 3rd transfer of sweep 0..9 → all outputs return to reset values asynchronously. A new sweep 0..1 then produces exactly 2 words with checksum=3.
